mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter for the single unified memory of the multicycle ARM core.
//  Port A is the CPU (the Adr / WriteData / MemWrite path of top).
//  Port B is an external master (program loader / debug DMA).
//  Registered, round-robin ownership, one transfer per granted cycle.
//  Optional bounded burst lock for the external master.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MAX_LOCK    8   max consecutive locked EXT grants while CPU waits (>=1)
//  LOCK_CNT_W  4   width of lock counter; must hold MAX_LOCK
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  cpu_req    in   1       CPU requests a transfer; held until cpu_gnt seen
//  cpu_we     in   1       1=write, 0=read
//  cpu_adr    in   ADDR_W  CPU byte address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_gnt    out  1       CPU owns memory this cycle
//  cpu_rdata  out  DATA_W  read data; valid when cpu_gnt & cpu_req & !cpu_we
//  ext_req    in   1       external request; held until ext_gnt seen
//  ext_we     in   1       1=write, 0=read
//  ext_lock   in   1       request to keep ownership for a burst
//  ext_adr    in   ADDR_W  external address
//  ext_wdata  in   DATA_W  external write data
//  ext_gnt    out  1       external master owns memory this cycle
//  ext_rdata  out  DATA_W  read data; valid when ext_gnt & ext_req & !ext_we
//  mem_adr    out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_we     out  1       memory write enable (write commits at next rising edge)
//  mem_rdata  in   DATA_W  combinational memory read data
// BEHAVIOUR
//  Reset: state=S_IDLE, last_owner=EXT, lock_cnt=0.
//    Outputs go low immediately: cpu_gnt=0, ext_gnt=0, mem_we=0, mem_adr=0, mem_wdata=0.
//  FSM states: S_IDLE, S_CPU, S_EXT. cpu_gnt=(state==S_CPU), ext_gnt=(state==S_EXT).
//  Next state is evaluated at every rising edge from the current req/lock inputs:
//    - No req: S_IDLE.
//    - One req: that requester.
//    - Both req, S_IDLE: owner != last_owner (CPU first after reset).
//    - Both req, S_CPU: go to S_EXT.
//    - Both req, S_EXT, ext_lock=0: go to S_CPU.
//    - Both req, S_EXT, ext_lock=1, lock_cnt<MAX_LOCK-1: stay S_EXT, lock_cnt++.
//    - Both req, S_EXT, ext_lock=1, lock_cnt==MAX_LOCK-1: forced to S_CPU.
//  lock_cnt clears on any edge where next state != S_EXT or cpu_req=0.
//  last_owner updates to the owner of every granted cycle.
//  Latency: req rising in cycle N with S_IDLE -> gnt in cycle N+1. Switching owners costs no bubble.
//  Datapath muxes follow the state:
//    - S_CPU: mem_adr/mem_wdata=cpu_*; mem_we=cpu_req&cpu_we.
//    - S_EXT: the same with ext_*.
//    - S_IDLE: mem_adr=0, mem_wdata=0, mem_we=0.
//    - A granted requester that drops req gets no transfer: mem_we=0 that cycle.
//  mem_rdata drives both cpu_rdata and ext_rdata unregistered; the gnt qualifies which is valid.
//  Reset mid-transfer: mem_we falls asynchronously and the write is lost. The requester must reissue it.
//  Never both gnts high. mem_we never high in S_IDLE.
// STRUCTURE
//  Shared include mem_arb_defs.vh holds:
//    - state encodings S_IDLE=2'd0, S_CPU=2'd1, S_EXT=2'd2
//    - owner encodings OWN_CPU=1'b0, OWN_EXT=1'b1
//  One sub-module, lock_counter: clear, increment, saturating at MAX_LOCK-1, terminal flag.
//  The rest is one FSM always block plus combinational muxes.
// TESTING
//  1 reset=1 with both reqs high -> cpu_gnt=0, ext_gnt=0, mem_we=0, mem_adr=0 throughout.
//  2 CPU write only (adr=100, wdata=7, we=1) at cycle N -> cycle N+1: cpu_gnt=1, mem_adr=100, mem_wdata=7, mem_we=1.
//  3 Both req held, no lock -> grants CPU,EXT,CPU,EXT... Never both high, no idle cycles.
//  4 ext_lock=1, both req held, MAX_LOCK=8, starting in S_EXT -> exactly 8 ext_gnt cycles, then 1 cpu_gnt.
//  5 EXT read adr=96 with mem_rdata=32'h1234 -> ext_gnt=1, ext_rdata=32'h1234, mem_we=0.
//  6 reset pulsed mid-cycle during an ext write -> mem_we and ext_gnt fall before the next edge. After release, CPU wins the tie.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter_pkg                                           |
// | Purpose  : Shared state/owner encodings for the memory arbiter.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  // Arbiter ownership state; the grant outputs decode directly from it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_EXT  = 2'd2
  } arb_state_t;

  // Who held the memory in the most recent granted cycle.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // Owner associated with a granted state (S_IDLE never reaches here).
  function automatic owner_t owner_of(arb_state_t s);
    return (s == S_EXT) ? OWN_EXT : OWN_CPU;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                            |
// | Purpose  : CPU, external-master and memory bus bundle for the        |
// |            unified-memory arbiter.                                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;

  // External master port
  logic              ext_req;
  logic              ext_we;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_adr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;

  // Memory port
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus memory: everything the arbiter does not drive.
  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output ext_req, ext_we, ext_lock, ext_adr, ext_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, ext_gnt, ext_rdata,
    input  mem_adr, mem_wdata, mem_we
  );

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  ext_req, ext_we, ext_lock, ext_adr, ext_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, ext_gnt, ext_rdata,
    output mem_adr, mem_wdata, mem_we
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_lock_counter.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter_lock_counter                                  |
// | Purpose  : Counts consecutive locked EXT grants while the CPU waits; |
// |            saturates at MAX_LOCK-1 and flags the terminal value.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter_lock_counter #(
  parameter int MAX_LOCK   = 8,
  parameter int LOCK_CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [LOCK_CNT_W-1:0] TERM_VAL = LOCK_CNT_W'(MAX_LOCK - 1);

  logic [LOCK_CNT_W-1:0] cnt;

  // Clear has priority; increment stops at the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !term) begin
      cnt <= cnt + LOCK_CNT_W'(1);
    end
  end

  assign term = (cnt == TERM_VAL);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter                                               |
// | Purpose  : Round-robin arbiter between the CPU and an external       |
// |            master for one unified memory, with a bounded EXT burst   |
// |            lock.                                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = 8,
  parameter int LOCK_CNT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  import mem_arbiter_pkg::*;

  arb_state_t        state;
  arb_state_t        next_state;
  owner_t            last_owner;
  logic              both_req;
  logic              lock_clr;
  logic              lock_inc;
  logic              lock_term;
  logic [ADDR_W-1:0] adr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  assign both_req = bus.cpu_req & bus.ext_req;

  // Ownership decision for the coming edge from the current requests.
  always_comb begin
    next_state = S_IDLE;
    if (!bus.cpu_req && !bus.ext_req) begin
      next_state = S_IDLE;
    end else if (bus.cpu_req && !bus.ext_req) begin
      next_state = S_CPU;
    end else if (!bus.cpu_req && bus.ext_req) begin
      next_state = S_EXT;
    end else begin
      case (state)
        S_IDLE:  next_state = (last_owner == OWN_EXT) ? S_CPU : S_EXT;
        S_CPU:   next_state = S_EXT;
        S_EXT:   next_state = (bus.ext_lock && !lock_term) ? S_EXT : S_CPU;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Lock streak only grows while EXT keeps the bus against a waiting CPU.
  assign lock_inc = both_req && (state == S_EXT) && bus.ext_lock && !lock_term;
  assign lock_clr = (next_state != S_EXT) || !bus.cpu_req;

  mem_arbiter_lock_counter #(
    .MAX_LOCK   (MAX_LOCK),
    .LOCK_CNT_W (LOCK_CNT_W)
  ) u_lock_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (lock_clr),
    .inc   (lock_inc),
    .term  (lock_term)
  );

  // Ownership register and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_owner <= OWN_EXT;
    end else begin
      state <= next_state;
      if (state != S_IDLE) begin
        last_owner <= owner_of(state);
      end
    end
  end

  // Memory-side muxes follow the owner; a granted requester that dropped
  // its request produces no write.
  always_comb begin
    adr_mux   = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    case (state)
      S_CPU: begin
        adr_mux   = bus.cpu_adr;
        wdata_mux = bus.cpu_wdata;
        we_mux    = bus.cpu_req & bus.cpu_we;
      end
      S_EXT: begin
        adr_mux   = bus.ext_adr;
        wdata_mux = bus.ext_wdata;
        we_mux    = bus.ext_req & bus.ext_we;
      end
      default: begin
        adr_mux   = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
      end
    endcase
  end

  assign bus.cpu_gnt   = (state == S_CPU);
  assign bus.ext_gnt   = (state == S_EXT);
  assign bus.mem_adr   = adr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = we_mux;

  // Read data is shared; the grant tells each side when it is valid.
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;

endmodule

`default_nettype wire
